// File: rtl/operand_stage_pkg.sv
// Shared types and constants for the operand stage.
// Covers branch-condition encodings, FSM states, widths and a saturating counter helper.
package operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  // Codes 6 and 7 are deliberately left unnamed; they decode as never-taken.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } branch_cond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } stage_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/operand_stage_branch_compare.sv
// Combinational branch resolver.
// Compares operands as signed 32-bit values; rt is only consulted for beq/bne.
module branch_compare
  import operand_stage_pkg::*;
(
  input  logic [2:0]        cond,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              taken
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[DATA_W-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    taken = 1'b0;
    case (branch_cond_e'(cond))
      BR_BEQ:  taken = (rs == rt);
      BR_BNE:  taken = (rs != rt);
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = ~rs_neg & ~rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = ~rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: EX operand forwarding, load-use and branch/jr stalls, early branch redirect.
// Also maintains saturating stall counters.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              PIPELINE_READY,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_s_branch,
  input  logic              id_s_jr,
  input  logic [2:0]        id_branch_cond,
  input  logic [DATA_W-1:0] id_branch_target,
  input  logic              s_loaduse,
  input  logic              s_branch_jr_ok,
  input  logic              s_rs_fastforward,
  input  logic              s_rs_fastforward_bj,
  input  logic [DATA_W-1:0] d_rs_fastforward,
  input  logic              s_rt_fastforward,
  input  logic              s_rt_fastforward_bj,
  input  logic [DATA_W-1:0] d_rt_fastforward,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  cnt_loaduse,
  output logic [CNT_W-1:0]  cnt_bj_stall
);

  stage_state_e      state;
  logic [DATA_W-1:0] ex_rs_raw;
  logic [DATA_W-1:0] ex_rt_raw;
  logic [DATA_W-1:0] bj_rs;
  logic [DATA_W-1:0] bj_rt;
  logic              bj_stall;
  logic              bj_resolve;
  logic              br_taken;
  logic              br_fire;
  logic              jr_fire;

  // Load-use and unresolved branch/jr operands share one bubble.
  assign bj_stall = (id_s_branch | id_s_jr) & ~s_branch_jr_ok;
  assign id_stall = id_valid & (s_loaduse | bj_stall);

  assign ex_rs_val = s_rs_fastforward ? d_rs_fastforward : ex_rs_raw;
  assign ex_rt_val = s_rt_fastforward ? d_rt_fastforward : ex_rt_raw;

  assign bj_rs = s_rs_fastforward_bj ? d_rs_fastforward : id_rs_data;
  assign bj_rt = s_rt_fastforward_bj ? d_rt_fastforward : id_rt_data;

  branch_compare u_branch_compare (
    .cond  (id_branch_cond),
    .rs    (bj_rs),
    .rt    (bj_rt),
    .taken (br_taken)
  );

  // A branch takes priority should both decode flags ever be set together.
  assign bj_resolve = id_valid & s_branch_jr_ok & ~s_loaduse;
  assign br_fire    = bj_resolve & id_s_branch & br_taken;
  assign jr_fire    = bj_resolve & id_s_jr & ~id_s_branch;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_RUN;
      ex_valid       <= 1'b0;
      ex_rs_raw      <= '0;
      ex_rt_raw      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cnt_loaduse    <= '0;
      cnt_bj_stall   <= '0;
    end else if (PIPELINE_READY) begin
      case (state)
        ST_RUN:  if (id_stall)  state <= ST_HOLD;
        ST_HOLD: if (!id_stall) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase

      ex_valid <= id_valid & ~id_stall;
      if (!id_stall) begin
        ex_rs_raw <= id_rs_data;
        ex_rt_raw <= id_rt_data;
      end

      // Redirect steers fetch only; the delay slot in ID still issues.
      redirect_valid <= br_fire | jr_fire;
      if (br_fire) begin
        redirect_pc <= id_branch_target;
      end else if (jr_fire) begin
        redirect_pc <= bj_rs;
      end

      if (id_valid & s_loaduse) begin
        cnt_loaduse <= sat_inc(cnt_loaduse);
      end
      if (id_valid & bj_stall & ~s_loaduse) begin
        cnt_bj_stall <= sat_inc(cnt_bj_stall);
      end
    end
  end

endmodule
